microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//   Generates the 14-bit micro-address that indexes the 15-byte microcode control ROM, one address per clock.
//   Inputs are the sequencing fields of the current control word (typ, offset, cond_*, escape), the flags and the IR opcode.
//   Sits directly upstream of the control ROM: u_addr_o -> ROM -> control word -> fields fed back here.
// PARAMETERS
//   U_ADDR_W        14   micro-address width (256 opcodes x 64 steps)
//   OFFSET_W         7   signed branch offset width (control word offset_0..offset_6)
//   STEPS_LOG2       6   log2(CYCLES_PER_INSTRUCTION), opcode page size
//   RESET_U_ADDR     0   micro-address loaded by reset
//   FETCH_U_ADDR    16   instruction fetch routine entry
//   TRAP_U_ADDR     32   interrupt/trap routine entry
// PORTS
//   clk            in   1   core clock, all state on rising edge
//   arst           in   1   asynchronous reset, active-low
//   typ_i          in   2   control word typ1:typ0
//   offset_i       in   7   control word offset_6..0, two's complement
//   cond_invert_i  in   1   invert selected condition
//   cond_flag_src_i in  1   0 = CPU status flags, 1 = micro-flags
//   cond_sel_i     in   4   condition select
//   escape_i       in   1   wait-state step marker
//   status_flags_i in   4   {of,sf,cf,zf} from status register
//   u_flags_i      in   4   {u_of,u_sf,u_cf,u_zf} micro-flags
//   ir_i           in   8   current opcode from IR
//   int_pending_i  in   1   masked interrupt request pending
//   irq_en_i       in   1   status interrupt-enable bit
//   dma_req_i      in   1   DMA request
//   mode_i         in   1   1 = supervisor
//   wait_i         in   1   memory/IO not ready
//   halt_i         in   1   freeze sequencer (panel single-step/halt)
//   u_addr_o       out 14   registered micro-address to control ROM
//   cond_o         out  1   final condition (after invert), combinational
//   fetch_o        out  1   registered: u_addr_o == FETCH_U_ADDR this cycle
//   int_taken_o    out  1   registered one-cycle pulse: trap entry taken
// BEHAVIOUR
//   Reset (arst low, async): u_addr_o=RESET_U_ADDR, fetch_o=0, int_taken_o=0. First post-reset edge follows typ decode.
//   Flag vector F = cond_flag_src_i ? u_flags_i : status_flags_i.
//   cond_sel: 0 zf, 1 cf, 2 sf, 3 of, 4 sf^of, 5 zf|(sf^of), 6 zf|cf, 7 int_pending_i&irq_en_i,
//     8 dma_req_i, 9 mode_i, 10 wait_i, 11-14 constant 0, 15 constant 1. cond_o = sel ^ cond_invert_i.
//   Next-address priority per edge (highest first):
//     1 halt_i=1: hold u_addr_o; int_taken_o=0.
//     2 escape_i=1 and wait_i=1: hold u_addr_o (wait-state; control word re-issued unchanged).
//     3 typ=00 OFFSET:     u_addr + sext(offset_i), unconditional (offset 1 = sequential).
//     4 typ=01 BRANCH:     cond_o ? u_addr + sext(offset_i) : u_addr + 1.
//     5 typ=10 PRE_FETCH:  (int_pending_i & irq_en_i) ? TRAP_U_ADDR, int_taken_o=1 next cycle : FETCH_U_ADDR.
//     6 typ=11 POST_FETCH: {ir_i, 6'b0} (opcode page entry).
//   Arithmetic: 14-bit, modulo 2^14; 0x3FFF+1 -> 0x0000, 0x0000+(-1) -> 0x3FFF. No page-boundary clamp.
//   Offset range -64..+63; offset 0 is a legal self-loop.
//   Latency: next address registered 1 cycle after control word sampled; ROM read adds its own cycle (outside block).
//   int_taken_o: exactly one cycle per trap entry; never asserted while halted; cleared every other cycle.
//   fetch_o tracks registered u_addr_o (also true after a branch landing on FETCH_U_ADDR).
//   Simultaneous: halt and wait -> halt wins; interrupt arriving on a non-PRE_FETCH step is ignored until next PRE_FETCH.
//   Reset mid-wait or mid-halt: async return to RESET_U_ADDR, pending wait state discarded.
//   ir_i sampled only on POST_FETCH edge; block holds no copy of the opcode.
// TESTING
//   Reset: arst low at u_addr 0x1234 -> u_addr_o=0x0000 immediately, fetch_o=0, int_taken_o=0.
//   OFFSET chain: typ=00,off=1 from 0x0100 x3 -> 0x0101,0x0102,0x0103; off=7'h7F at 0x0000 -> 0x3FFF.
//   BRANCH: u_addr 0x0200, sel=0 src=0 zf=1 inv=0 off=+5 -> 0x0205; same with inv=1 -> 0x0201; sel=15 inv=1 -> 0x0201.
//   PRE/POST: typ=10 no irq -> 0x0010, fetch_o=1; then typ=11 ir=0xA3 -> 0x28C0.
//   Interrupt: typ=10, int_pending=1, irq_en=1 -> 0x0020, int_taken_o=1 for 1 cycle; irq_en=0 -> 0x0010.
//   Wait/halt: escape=1,wait=1 for 3 cycles -> u_addr held 3 cycles then advances; halt=1 with wait -> held, no pulse.

Source files
------------

// File: rtl/microcode_sequencer_if.sv
// Sequencing bundle between the control ROM/datapath and the microcode sequencer.
// Carries control-word fields, flags, and the opcode towards the sequencer, plus the micro-address and status outputs back.
// No flow control: the sequencer consumes one control word per clock unless frozen by halt or wait.
interface microcode_sequencer_if #(
  parameter int unsigned U_ADDR_W = 14,
  parameter int unsigned OFFSET_W = 7
);
  logic [1:0]          typ_i;
  logic [OFFSET_W-1:0] offset_i;
  logic                cond_invert_i;
  logic                cond_flag_src_i;
  logic [3:0]          cond_sel_i;
  logic                escape_i;
  logic [3:0]          status_flags_i;   // {of,sf,cf,zf}
  logic [3:0]          u_flags_i;        // {u_of,u_sf,u_cf,u_zf}
  logic [7:0]          ir_i;
  logic                int_pending_i;
  logic                irq_en_i;
  logic                dma_req_i;
  logic                mode_i;
  logic                wait_i;
  logic                halt_i;
  logic [U_ADDR_W-1:0] u_addr_o;
  logic                cond_o;
  logic                fetch_o;
  logic                int_taken_o;

  // Control ROM / datapath side.
  modport master (
    output typ_i, offset_i, cond_invert_i, cond_flag_src_i, cond_sel_i, escape_i,
           status_flags_i, u_flags_i, ir_i, int_pending_i, irq_en_i, dma_req_i,
           mode_i, wait_i, halt_i,
    input  u_addr_o, cond_o, fetch_o, int_taken_o
  );

  // Sequencer side.
  modport slave (
    input  typ_i, offset_i, cond_invert_i, cond_flag_src_i, cond_sel_i, escape_i,
           status_flags_i, u_flags_i, ir_i, int_pending_i, irq_en_i, dma_req_i,
           mode_i, wait_i, halt_i,
    output u_addr_o, cond_o, fetch_o, int_taken_o
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: computes the next 14-bit micro-address for the control ROM from the current control word.
// Latency: u_addr_o/fetch_o/int_taken_o registered one cycle after the control word is sampled; cond_o is combinational.
// Backpressure: halt_i freezes the address; escape_i with wait_i holds it so the same control word is re-issued.
// Ports: clk, arst (async active-low), bus (slave modport: control-word fields, flags, ir in; u_addr/cond/fetch/int_taken out).
module microcode_sequencer #(
  parameter int unsigned U_ADDR_W     = 14,
  parameter int unsigned OFFSET_W     = 7,
  parameter int unsigned STEPS_LOG2   = 6,
  parameter int unsigned RESET_U_ADDR = 0,
  parameter int unsigned FETCH_U_ADDR = 16,
  parameter int unsigned TRAP_U_ADDR  = 32
) (
  input logic                 clk,
  input logic                 arst,
  microcode_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    TYP_OFFSET     = 2'b00,
    TYP_BRANCH     = 2'b01,
    TYP_PRE_FETCH  = 2'b10,
    TYP_POST_FETCH = 2'b11
  } typ_e;

  localparam logic [U_ADDR_W-1:0] RESET_A = U_ADDR_W'(RESET_U_ADDR);
  localparam logic [U_ADDR_W-1:0] FETCH_A = U_ADDR_W'(FETCH_U_ADDR);
  localparam logic [U_ADDR_W-1:0] TRAP_A  = U_ADDR_W'(TRAP_U_ADDR);

  typ_e                typ;
  logic [3:0]          flags;
  logic                cond_raw;
  logic                cond;
  logic                irq_ok;
  logic [U_ADDR_W-1:0] off_sext;
  logic [U_ADDR_W-1:0] u_addr_q, u_addr_d;
  logic                fetch_q, fetch_d;
  logic                int_taken_q, int_taken_d;

  assign typ      = typ_e'(bus.typ_i);
  assign irq_ok   = bus.int_pending_i & bus.irq_en_i;
  // Two's complement offset widened to address width; the add then wraps modulo 2^U_ADDR_W.
  assign off_sext = {{(U_ADDR_W-OFFSET_W){bus.offset_i[OFFSET_W-1]}}, bus.offset_i};

  // Condition multiplexer; flags are {of,sf,cf,zf}.
  always_comb begin
    flags    = bus.cond_flag_src_i ? bus.u_flags_i : bus.status_flags_i;
    cond_raw = 1'b0;
    case (bus.cond_sel_i)
      4'd0:    cond_raw = flags[0];
      4'd1:    cond_raw = flags[1];
      4'd2:    cond_raw = flags[2];
      4'd3:    cond_raw = flags[3];
      4'd4:    cond_raw = flags[2] ^ flags[3];
      4'd5:    cond_raw = flags[0] | (flags[2] ^ flags[3]);
      4'd6:    cond_raw = flags[0] | flags[1];
      4'd7:    cond_raw = irq_ok;
      4'd8:    cond_raw = bus.dma_req_i;
      4'd9:    cond_raw = bus.mode_i;
      4'd10:   cond_raw = bus.wait_i;
      4'd15:   cond_raw = 1'b1;
      default: cond_raw = 1'b0;
    endcase
    cond = cond_raw ^ bus.cond_invert_i;
  end

  // Next micro-address: halt beats wait-state, which beats typ decode.
  always_comb begin
    u_addr_d    = u_addr_q;
    int_taken_d = 1'b0;
    if (bus.halt_i) begin
      u_addr_d = u_addr_q;
    end else if (bus.escape_i && bus.wait_i) begin
      u_addr_d = u_addr_q;
    end else begin
      case (typ)
        TYP_OFFSET:     u_addr_d = u_addr_q + off_sext;
        TYP_BRANCH:     u_addr_d = cond ? (u_addr_q + off_sext) : (u_addr_q + 1'b1);
        TYP_PRE_FETCH: begin
          u_addr_d    = irq_ok ? TRAP_A : FETCH_A;
          int_taken_d = irq_ok;
        end
        TYP_POST_FETCH: u_addr_d = {bus.ir_i, {STEPS_LOG2{1'b0}}};
        default:        u_addr_d = u_addr_q;
      endcase
    end
    // Registered alongside the address so it tracks every landing on the fetch entry.
    fetch_d = (u_addr_d == FETCH_A);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      u_addr_q    <= RESET_A;
      fetch_q     <= 1'b0;
      int_taken_q <= 1'b0;
    end else begin
      u_addr_q    <= u_addr_d;
      fetch_q     <= fetch_d;
      int_taken_q <= int_taken_d;
    end
  end

  assign bus.u_addr_o    = u_addr_q;
  assign bus.cond_o      = cond;
  assign bus.fetch_o     = fetch_q;
  assign bus.int_taken_o = int_taken_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: reset, offset chain and wrap, branch/condition select,
// pre/post fetch, trap entry pulse, wait-state hold, halt priority, and reset during halt.
module tb_microcode_sequencer;

  logic clk;
  logic arst;
  int   checks;
  int   errors;
  logic [15:0] cond_tbl;

  microcode_sequencer_if bus ();

  microcode_sequencer dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    bus.typ_i           = 2'b00;
    bus.offset_i        = 7'd0;
    bus.cond_invert_i   = 1'b0;
    bus.cond_flag_src_i = 1'b0;
    bus.cond_sel_i      = 4'd0;
    bus.escape_i        = 1'b0;
    bus.status_flags_i  = 4'd0;
    bus.u_flags_i       = 4'd0;
    bus.ir_i            = 8'd0;
    bus.int_pending_i   = 1'b0;
    bus.irq_en_i        = 1'b0;
    bus.dma_req_i       = 1'b0;
    bus.mode_i          = 1'b0;
    bus.wait_i          = 1'b0;
    bus.halt_i          = 1'b0;
  endtask

  // Jump to opcode page via POST_FETCH.
  task automatic goto_page(input logic [7:0] op);
    defaults();
    bus.typ_i = 2'b11;
    bus.ir_i  = op;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    defaults();
    arst = 1'b0;
    #1;
    chk("por_u_addr", bus.u_addr_o, 16'h0000);
    chk("por_fetch", bus.fetch_o, 16'h0);
    chk("por_int_taken", bus.int_taken_o, 16'h0);
    @(negedge clk);
    arst = 1'b1;
    step();
    chk("post_reset_selfloop", bus.u_addr_o, 16'h0000);

    // Reach 0x1234 then reset asynchronously.
    goto_page(8'h48);
    chk("page_48", bus.u_addr_o, 16'h1200);
    bus.typ_i = 2'b00; bus.offset_i = 7'h34;
    step();
    chk("offset_to_1234", bus.u_addr_o, 16'h1234);
    defaults();
    arst = 1'b0;
    #1;
    chk("async_rst_u_addr", bus.u_addr_o, 16'h0000);
    chk("async_rst_fetch", bus.fetch_o, 16'h0);
    chk("async_rst_int", bus.int_taken_o, 16'h0);
    #2 arst = 1'b1;

    // OFFSET chain and wrap in both directions.
    goto_page(8'h04);
    chk("page_04", bus.u_addr_o, 16'h0100);
    bus.typ_i = 2'b00; bus.offset_i = 7'd1;
    step(); chk("seq_0101", bus.u_addr_o, 16'h0101);
    step(); chk("seq_0102", bus.u_addr_o, 16'h0102);
    step(); chk("seq_0103", bus.u_addr_o, 16'h0103);
    goto_page(8'h00);
    chk("page_00", bus.u_addr_o, 16'h0000);
    bus.typ_i = 2'b00; bus.offset_i = 7'h7F;
    step(); chk("wrap_down", bus.u_addr_o, 16'h3FFF);
    bus.offset_i = 7'd1;
    step(); chk("wrap_up", bus.u_addr_o, 16'h0000);

    // BRANCH on zf.
    goto_page(8'h08);
    bus.typ_i = 2'b01; bus.cond_sel_i = 4'd0; bus.status_flags_i = 4'b0001; bus.offset_i = 7'd5;
    #1 chk("cond_zf", bus.cond_o, 16'h1);
    step(); chk("br_taken", bus.u_addr_o, 16'h0205);
    goto_page(8'h08);
    bus.typ_i = 2'b01; bus.cond_sel_i = 4'd0; bus.status_flags_i = 4'b0001; bus.offset_i = 7'd5;
    bus.cond_invert_i = 1'b1;
    step(); chk("br_inv_not_taken", bus.u_addr_o, 16'h0201);
    goto_page(8'h08);
    bus.typ_i = 2'b01; bus.cond_sel_i = 4'd15; bus.cond_invert_i = 1'b1; bus.offset_i = 7'd5;
    step(); chk("br_const1_inv", bus.u_addr_o, 16'h0201);
    goto_page(8'h08);
    bus.typ_i = 2'b01; bus.cond_sel_i = 4'd0; bus.cond_flag_src_i = 1'b1;
    bus.status_flags_i = 4'b0001; bus.u_flags_i = 4'b0000; bus.offset_i = 7'd5;
    step(); chk("br_uflag_src", bus.u_addr_o, 16'h0201);

    // Condition select table: sf=1 cf=1, int_pending without enable, dma=1, mode=0, wait=1.
    defaults();
    bus.status_flags_i = 4'b0110;
    bus.int_pending_i  = 1'b1;
    bus.dma_req_i      = 1'b1;
    bus.wait_i         = 1'b1;
    cond_tbl = 16'h8576;
    for (int s = 0; s < 16; s++) begin
      bus.cond_sel_i = 4'(s);
      #1;
      chk($sformatf("cond_sel_%0d", s), bus.cond_o, {15'd0, cond_tbl[s]});
    end
    bus.cond_sel_i = 4'd3; bus.cond_invert_i = 1'b1;
    #1 chk("cond_of_inv", bus.cond_o, 16'h1);
    bus.cond_invert_i = 1'b0; bus.cond_flag_src_i = 1'b1; bus.u_flags_i = 4'b1000;
    #1 chk("cond_uof", bus.cond_o, 16'h1);

    // PRE_FETCH then POST_FETCH.
    defaults();
    step();
    bus.typ_i = 2'b10;
    step();
    chk("prefetch_addr", bus.u_addr_o, 16'h0010);
    chk("prefetch_fetch", bus.fetch_o, 16'h1);
    chk("prefetch_no_int", bus.int_taken_o, 16'h0);
    bus.typ_i = 2'b11; bus.ir_i = 8'hA3;
    step();
    chk("postfetch_addr", bus.u_addr_o, 16'h28C0);
    chk("postfetch_fetch", bus.fetch_o, 16'h0);

    // Trap entry: single-cycle pulse.
    bus.typ_i = 2'b10; bus.int_pending_i = 1'b1; bus.irq_en_i = 1'b1;
    step();
    chk("trap_addr", bus.u_addr_o, 16'h0020);
    chk("trap_pulse", bus.int_taken_o, 16'h1);
    bus.typ_i = 2'b00; bus.offset_i = 7'd1;
    step();
    chk("trap_pulse_end", bus.int_taken_o, 16'h0);
    chk("irq_ignored_offset", bus.u_addr_o, 16'h0021);
    bus.typ_i = 2'b10; bus.irq_en_i = 1'b0;
    step();
    chk("masked_irq_addr", bus.u_addr_o, 16'h0010);
    chk("masked_irq_pulse", bus.int_taken_o, 16'h0);
    bus.typ_i = 2'b00; bus.offset_i = 7'd1; bus.irq_en_i = 1'b1;
    step();
    chk("irq_non_prefetch", bus.u_addr_o, 16'h0011);
    chk("irq_non_prefetch_pulse", bus.int_taken_o, 16'h0);

    // Branch landing on fetch entry raises fetch_o.
    defaults();
    bus.typ_i = 2'b01; bus.cond_sel_i = 4'd15; bus.offset_i = 7'h7F;
    step();
    chk("br_to_fetch_addr", bus.u_addr_o, 16'h0010);
    chk("br_to_fetch_flag", bus.fetch_o, 16'h1);

    // Wait-state hold for three cycles, then advance.
    bus.typ_i = 2'b00; bus.offset_i = 7'd1; bus.escape_i = 1'b1; bus.wait_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait_hold_%0d", i), bus.u_addr_o, 16'h0010);
    end
    bus.wait_i = 1'b0;
    step();
    chk("wait_release", bus.u_addr_o, 16'h0011);

    // Halt with wait and a pending trap: held, no pulse.
    bus.halt_i = 1'b1; bus.wait_i = 1'b1; bus.typ_i = 2'b10;
    bus.int_pending_i = 1'b1; bus.irq_en_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("halt_hold_%0d", i), bus.u_addr_o, 16'h0011);
      chk($sformatf("halt_no_pulse_%0d", i), bus.int_taken_o, 16'h0);
    end
    bus.halt_i = 1'b0; bus.escape_i = 1'b0; bus.wait_i = 1'b0;
    step();
    chk("unhalt_trap_addr", bus.u_addr_o, 16'h0020);
    chk("unhalt_trap_pulse", bus.int_taken_o, 16'h1);

    // Reset while halted.
    bus.halt_i = 1'b1;
    step();
    arst = 1'b0;
    #1;
    chk("rst_in_halt_addr", bus.u_addr_o, 16'h0000);
    chk("rst_in_halt_pulse", bus.int_taken_o, 16'h0);
    #2 arst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
